pc_gen: RTL and testbench

- Parametrised program-counter generator for the rv32i core. Replaces the free-running +4 counter.
- Selects the next fetch address from a reset vector, sequential increment, branch, jump, trap entry and trap return.
- Supports stall and a debug halt/resume FSM, and detects misaligned control-flow targets, which it converts into a trap redirect with captured cause data.
- Sits in the fetch stage and drives the instruction-memory address.

---
 rtl/pc_gen_if.sv | 36 +++
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage control bundle between the core pipeline and the PC generator.
// The master side is the pipeline (redirects, stall, debug); the slave side
// is pc_gen, which returns the fetch address and trap bookkeeping.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            jmp_valid;
  logic [XLEN-1:0] jmp_target;
  logic            trap_req;
  logic            mret;
  logic            halt_req;
  logic            resume;
  logic            is_c;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            pc_valid;
  logic            halted;
  logic            misalign_exc;
  logic [XLEN-1:0] bad_addr;
  logic [XLEN-1:0] epc;

  modport master (
    output stall, br_taken, br_target, jmp_valid, jmp_target,
           trap_req, mret, halt_req, resume, is_c,
    input  pc, pc_next, pc_valid, halted, misalign_exc, bad_addr, epc
  );

  modport slave (
    input  stall, br_taken, br_target, jmp_valid, jmp_target,
           trap_req, mret, halt_req, resume, is_c,
    output pc, pc_next, pc_valid, halted, misalign_exc, bad_addr, epc
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the rv32i fetch stage.
//
// state | meaning
// BOOT  | first cycle after reset, pc parked at RESET_VEC, not yet valid
// RUN   | fetching; pc advances or redirects every cycle
// HALT  | debug halt; pc frozen, only trap_req can move it
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              IALIGN    = 32
) (
  input logic   clk,
  input logic   rst,
  pc_gen_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] step;

  // With compressed support only bit 0 must be clear; otherwise bits [1:0].
  function automatic logic is_misaligned(input logic [XLEN-1:0] t);
    if (IALIGN == 16) return t[0];
    else              return |t[1:0];
  endfunction

  // Sequential step is 2 only for a 16-bit instruction in a compressed build.
  always_comb begin
    step = XLEN'(4);
    if (IALIGN == 16 && bus.is_c) step = XLEN'(2);
  end

  // Next-state, next-PC and trap bookkeeping selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    bad_addr_d = bad_addr_q;
    misalign_d = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d    = RESET_VEC;
        state_d = RUN;
      end
      RUN: begin
        if (bus.trap_req) begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
        end else if (bus.mret) begin
          pc_d = epc_q;
        end else if (bus.jmp_valid) begin
          if (is_misaligned(bus.jmp_target)) begin
            pc_d       = TRAP_VEC;
            epc_d      = pc_q;
            bad_addr_d = bus.jmp_target;
            misalign_d = 1'b1;
          end else begin
            pc_d = bus.jmp_target;
          end
        end else if (bus.br_taken) begin
          if (is_misaligned(bus.br_target)) begin
            pc_d       = TRAP_VEC;
            epc_d      = pc_q;
            bad_addr_d = bus.br_target;
            misalign_d = 1'b1;
          end else begin
            pc_d = bus.br_target;
          end
        end else if (bus.halt_req) begin
          // Halt only when no redirect is pending; the instruction at pc is
          // re-fetched after resume, so pc is frozen here.
          state_d = HALT;
        end else if (!bus.stall) begin
          pc_d = pc_q + step;
        end
      end
      HALT: begin
        if (bus.trap_req) begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
        end
        if (bus.resume && !bus.halt_req) state_d = RUN;
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      bad_addr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      bad_addr_q <= bad_addr_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_next      = pc_d;
  assign bus.pc_valid     = (state_q == RUN);
  assign bus.halted       = (state_q == HALT);
  assign bus.misalign_exc = misalign_q;
  assign bus.bad_addr     = bad_addr_q;
  assign bus.epc          = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one IALIGN=32 instance and one IALIGN=16 instance.
module tb_pc_gen;
  logic clk;
  logic rst32;
  logic rst16;
  int   n_assert;
  int   n_fail;

  pc_gen_if #(.XLEN(32)) a32 ();
  pc_gen_if #(.XLEN(32)) a16 ();

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .IALIGN(32))
    u32 (.clk(clk), .rst(rst32), .bus(a32.slave));
  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .IALIGN(16))
    u16 (.clk(clk), .rst(rst16), .bus(a16.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr32();
    a32.stall = 0; a32.br_taken = 0; a32.br_target = '0; a32.jmp_valid = 0;
    a32.jmp_target = '0; a32.trap_req = 0; a32.mret = 0; a32.halt_req = 0;
    a32.resume = 0; a32.is_c = 0;
  endtask

  task automatic clr16();
    a16.stall = 0; a16.br_taken = 0; a16.br_target = '0; a16.jmp_valid = 0;
    a16.jmp_target = '0; a16.trap_req = 0; a16.mret = 0; a16.halt_req = 0;
    a16.resume = 0; a16.is_c = 0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clk   = 0;
    rst32 = 1;
    rst16 = 1;
    clr32();
    clr16();
    tick();
    tick();

    // Reset state
    chk("rst_pc", a32.pc, 32'h0);
    chk("rst_valid", 32'(a32.pc_valid), 32'h0);
    chk("rst_halted", 32'(a32.halted), 32'h0);
    chk("rst_mis", 32'(a32.misalign_exc), 32'h0);
    chk("rst_epc", a32.epc, 32'h0);
    chk("rst_bad", a32.bad_addr, 32'h0);

    // Boot sequence
    rst32 = 0;
    #1;
    chk("boot_valid", 32'(a32.pc_valid), 32'h0);
    chk("boot_pc", a32.pc, 32'h0);
    tick();
    chk("first_pc", a32.pc, 32'h0);
    chk("first_valid", 32'(a32.pc_valid), 32'h1);
    a32.is_c = 1;  // ignored for IALIGN=32
    tick();
    chk("seq_4", a32.pc, 32'h4);
    tick();
    chk("seq_8", a32.pc, 32'h8);
    a32.is_c = 0;
    tick();
    chk("seq_c", a32.pc, 32'hC);
    tick();
    chk("seq_10", a32.pc, 32'h10);

    // Branch together with stall: redirect wins
    a32.br_taken = 1; a32.br_target = 32'h40; a32.stall = 1;
    #1;
    chk("br_pcnext", a32.pc_next, 32'h40);
    tick();
    chk("br_pc", a32.pc, 32'h40);
    a32.br_taken = 0;
    tick();
    chk("stall1", a32.pc, 32'h40);
    tick();
    chk("stall2", a32.pc, 32'h40);
    a32.stall = 0;

    // Misaligned jump then mret
    a32.jmp_valid = 1; a32.jmp_target = 32'h20;
    tick();
    chk("jmp_20", a32.pc, 32'h20);
    a32.jmp_target = 32'h102;
    tick();
    chk("mis_pc", a32.pc, 32'h100);
    chk("mis_epc", a32.epc, 32'h20);
    chk("mis_bad", a32.bad_addr, 32'h102);
    chk("mis_exc", 32'(a32.misalign_exc), 32'h1);
    a32.jmp_valid = 0;
    tick();
    chk("mis_pulse_end", 32'(a32.misalign_exc), 32'h0);
    chk("after_trap_seq", a32.pc, 32'h104);
    a32.mret = 1;
    #1;
    chk("mret_pcnext", a32.pc_next, 32'h20);
    tick();
    chk("mret_pc", a32.pc, 32'h20);
    a32.mret = 0;
    tick();
    chk("seq_24", a32.pc, 32'h24);

    // Trap beats jump and branch; misaligned branch target is not checked
    a32.trap_req = 1; a32.jmp_valid = 1; a32.jmp_target = 32'h80;
    a32.br_taken = 1; a32.br_target = 32'h41;
    tick();
    chk("trap_pc", a32.pc, 32'h100);
    chk("trap_epc", a32.epc, 32'h24);
    chk("trap_no_mis", 32'(a32.misalign_exc), 32'h0);
    chk("trap_bad_kept", a32.bad_addr, 32'h102);
    clr32();

    // Debug halt and resume
    a32.jmp_valid = 1; a32.jmp_target = 32'h30;
    tick();
    chk("jmp_30", a32.pc, 32'h30);
    a32.jmp_valid = 0; a32.halt_req = 1;
    tick();
    chk("halt_flag", 32'(a32.halted), 32'h1);
    chk("halt_pc", a32.pc, 32'h30);
    chk("halt_valid", 32'(a32.pc_valid), 32'h0);
    a32.br_taken = 1; a32.br_target = 32'h200; a32.resume = 1;
    tick();
    chk("halt_ignore_br", a32.pc, 32'h30);
    chk("halt_resume_blocked", 32'(a32.halted), 32'h1);
    a32.br_taken = 0; a32.halt_req = 0;
    tick();
    chk("resume_pc", a32.pc, 32'h30);
    chk("resume_valid", 32'(a32.pc_valid), 32'h1);
    a32.resume = 0;
    tick();
    chk("resume_seq", a32.pc, 32'h34);
    a32.halt_req = 1;
    tick();
    chk("halt2_pc", a32.pc, 32'h34);
    a32.trap_req = 1;
    tick();
    chk("halt_trap_pc", a32.pc, 32'h100);
    chk("halt_trap_epc", a32.epc, 32'h34);
    chk("halt_trap_stay", 32'(a32.halted), 32'h1);
    a32.trap_req = 0;
    rst32 = 1;
    tick();
    chk("rst_halt_pc", a32.pc, 32'h0);
    chk("rst_halt_flag", 32'(a32.halted), 32'h0);
    chk("rst_halt_valid", 32'(a32.pc_valid), 32'h0);
    rst32 = 0;
    tick();
    chk("reboot_pc", a32.pc, 32'h0);

    // Halt request together with a jump: jump first, halt next cycle
    a32.jmp_valid = 1; a32.jmp_target = 32'h50;
    tick();
    chk("halt_jmp_pc", a32.pc, 32'h50);
    chk("halt_jmp_not_halted", 32'(a32.halted), 32'h0);
    a32.jmp_valid = 0;
    tick();
    chk("halt_after_jmp", 32'(a32.halted), 32'h1);
    chk("halt_after_jmp_pc", a32.pc, 32'h50);
    clr32();

    // IALIGN=16 instance
    rst16 = 0;
    tick();
    chk("c_first", a16.pc, 32'h0);
    a16.jmp_valid = 1; a16.jmp_target = 32'h8;
    tick();
    chk("c_jmp8", a16.pc, 32'h8);
    a16.jmp_valid = 0; a16.is_c = 1;
    tick();
    chk("c_plus2", a16.pc, 32'hA);
    a16.is_c = 0;
    tick();
    chk("c_plus4", a16.pc, 32'hE);
    a16.jmp_valid = 1; a16.jmp_target = 32'h11;
    tick();
    chk("c_mis_pc", a16.pc, 32'h100);
    chk("c_mis_exc", 32'(a16.misalign_exc), 32'h1);
    chk("c_mis_bad", a16.bad_addr, 32'h11);
    chk("c_mis_epc", a16.epc, 32'hE);
    a16.jmp_target = 32'h12;
    tick();
    chk("c_aligned2", a16.pc, 32'h12);
    chk("c_no_mis", 32'(a16.misalign_exc), 32'h0);
    a16.jmp_target = 32'hFFFF_FFFC;
    tick();
    chk("c_top", a16.pc, 32'hFFFF_FFFC);
    a16.jmp_valid = 0;
    tick();
    chk("c_wrap", a16.pc, 32'h0);
    chk("c_wrap_no_mis", 32'(a16.misalign_exc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
